tick_gen: RTL and testbench

- Multi-channel programmable clock-enable generator, successor to the fixed divide-by-4 pixel strobe.
- Each channel emits a one-cycle tick every div[i] clk cycles, plus a registered ~50% duty square level.
- Divider values are writable at runtime and apply glitch-free at the channel's period boundary.
- Sits beside the VGA/camera pipelines and the plotter motor step timing, all in the single clk domain.

---
 rtl/tick_gen_pkg.sv | 20 ++
 rtl/tick_gen_ch.sv | 108 ++++++++++
 rtl/tick_gen.sv | 41 ++++
 tb/tb_tick_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared types and helpers for the programmable clock-enable generator.
package tick_gen_pkg;

    localparam int CNT_W_DEF       = 8;
    localparam int DEFAULT_DIV_DEF = 4;

    typedef logic [CNT_W_DEF-1:0] div_t;

    // A divider of zero would never wrap, so it behaves as divide-by-one.
    function automatic logic [31:0] eff_div(input logic [31:0] d);
        logic [31:0] r;
        if (d == 32'd0) begin
            r = 32'd1;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One tick/square channel with a shadowed divider that takes effect at period boundaries.
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sync_clr,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    output logic             tick,
    output logic             sq
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    logic [CNT_W-1:0] eff_s;
    logic [CNT_W-1:0] half_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] apply_val_s;
    logic             apply_s;
    logic             wrap_s;
    logic             boundary_s;

    assign eff_s       = CNT_W'(eff_div(32'(div_act_q)));
    assign half_s      = div_act_q >> 1;
    assign cnt_inc_s   = cnt_q + ONE;
    assign wrap_s      = (cnt_q == (eff_s - ONE));
    // A write on the boundary edge itself bypasses the shadow register.
    assign apply_val_s = wr ? wr_val : div_pend_q;
    assign apply_s     = wr | pend_vld_q;
    assign boundary_s  = sync_clr | (enable & wrap_s);

    // Next-state: boundary (wrap or realign) applies the divider, otherwise count/hold.
    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_vld_d = pend_vld_q;
        tick_d     = 1'b0;
        sq_d       = sq_q;
        if (boundary_s) begin
            cnt_d      = '0;
            tick_d     = ~sync_clr;
            sq_d       = ~sync_clr;
            div_pend_d = apply_val_s;
            pend_vld_d = 1'b0;
            if (apply_s) begin
                div_act_d = apply_val_s;
            end else begin
                div_act_d = div_act_q;
            end
        end else begin
            if (wr) begin
                div_pend_d = wr_val;
                pend_vld_d = 1'b1;
            end else begin
                div_pend_d = div_pend_q;
                pend_vld_d = pend_vld_q;
            end
            if (enable) begin
                cnt_d = cnt_inc_s;
                if ((half_s != '0) && (cnt_inc_s == half_s)) begin
                    sq_d = 1'b0;
                end else begin
                    sq_d = sq_q;
                end
            end else begin
                cnt_d = cnt_q;
                sq_d  = sq_q;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            div_act_q  <= DIV_RST;
            div_pend_q <= DIV_RST;
            pend_vld_q <= 1'b0;
            tick_q     <= 1'b0;
            sq_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_vld_q <= pend_vld_d;
            tick_q     <= tick_d;
            sq_q       <= sq_d;
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable clock-enable generator: write decode plus one channel per output bit.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int CNT_W       = CNT_W_DEF,
    parameter  int DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              sync_clr,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq
);

    // Channel indices at or above NUM_CH match no decoder, so such writes are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_s;
        assign wr_s = div_wr & (div_ch == CH_W'(i));

        tick_gen_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .enable   (enable),
            .sync_clr (sync_clr),
            .wr       (wr_s),
            .wr_val   (div_val),
            .tick     (tick[i]),
            .sq       (sq[i])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// Directed self-checking bench for tick_gen with two channels and default divide-by-4.
module tb_tick_gen;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       sync_clr;
    logic       div_wr;
    logic [0:0] div_ch;
    logic [7:0] div_val;
    logic [1:0] tick;
    logic [1:0] sq;

    int n_tests;
    int n_fail;
    int e;

    tick_gen #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .sync_clr (sync_clr),
        .div_wr   (div_wr),
        .div_ch   (div_ch),
        .div_val  (div_val),
        .tick     (tick),
        .sq       (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        enable   = 1'b0;
        sync_clr = 1'b0;
        div_wr   = 1'b0;
        div_ch   = 1'b0;
        div_val  = 8'd0;
        #12;
        check_eq("rst tick", 32'(tick), 32'd0);
        check_eq("rst sq", 32'(sq), 32'd0);
        reset_n = 1'b1;
        e = 0;
    endtask

    initial begin
        logic [1:0] et;
        logic [1:0] es;
        logic       b0;
        logic       b1;
        n_tests = 0;
        n_fail  = 0;
        e       = 0;

        // Scenario 1: default divide-by-4 on both channels.
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            b0 = (e % 4 == 0);
            b1 = (e >= 4) && ((e % 4 == 0) || (e % 4 == 1));
            et = {b0, b0};
            es = {b1, b1};
            check_eq($sformatf("s1 tick e%0d", e), 32'(tick), 32'(et));
            check_eq($sformatf("s1 sq e%0d", e), 32'(sq), 32'(es));
        end

        // Scenario 2: ch1 <- 3 at edge 2, applied at its wrap on edge 4.
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            if (k == 2) begin
                div_wr = 1'b1; div_ch = 1'b1; div_val = 8'd3;
            end
            step();
            div_wr = 1'b0;
            b0 = (e % 4 == 0);
            b1 = (e == 4) || ((e > 4) && ((e - 4) % 3 == 0));
            et = {b1, b0};
            check_eq($sformatf("s2 tick e%0d", e), 32'(tick), 32'(et));
            if (e == 5) begin
                check_eq("s2 sq1 half3 e5", 32'(sq[1]), 32'd0);
            end
        end

        // Scenario 3: ch0 <- 0 (acts as 1), then ch0 <- 5 on a wrap edge.
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            if (k == 1) begin
                div_wr = 1'b1; div_ch = 1'b0; div_val = 8'd0;
            end
            if (k == 9) begin
                div_wr = 1'b1; div_ch = 1'b0; div_val = 8'd5;
            end
            step();
            div_wr = 1'b0;
            if (e < 9) begin
                b0 = (e >= 4);
                b1 = (e >= 4);
            end else begin
                b0 = ((e - 9) % 5 == 0);
                b1 = ((e - 9) % 5 < 2);
            end
            check_eq($sformatf("s3 tick0 e%0d", e), 32'(tick[0]), 32'(b0));
            check_eq($sformatf("s3 sq0 e%0d", e), 32'(sq[0]), 32'(b1));
            check_eq($sformatf("s3 tick1 e%0d", e), 32'(tick[1]), 32'(e % 4 == 0));
        end

        // Scenario 4: enable low for edges 3..5 delays the first tick to edge 7.
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            if (k == 3) enable = 1'b0;
            if (k == 6) enable = 1'b1;
            step();
            b0 = (e == 7) || (e == 11);
            et = {b0, b0};
            check_eq($sformatf("s4 tick e%0d", e), 32'(tick), 32'(et));
        end

        // Scenario 5: sync_clr with ch0 <- 6 at edge 10.
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            if (k == 10) begin
                sync_clr = 1'b1; div_wr = 1'b1; div_ch = 1'b0; div_val = 8'd6;
            end
            step();
            sync_clr = 1'b0;
            div_wr   = 1'b0;
            if (e < 10) begin
                b0 = (e % 4 == 0);
                b1 = (e % 4 == 0);
            end else begin
                b0 = (e == 16) || (e == 22);
                b1 = (e == 14) || (e == 18) || (e == 22);
            end
            et = {b1, b0};
            check_eq($sformatf("s5 tick e%0d", e), 32'(tick), 32'(et));
            if (e == 9) check_eq("s5 sq before clr", 32'(sq), 32'd3);
            if (e == 10) check_eq("s5 sq after clr", 32'(sq), 32'd0);
        end

        // Scenario 6: reset dropped mid-count discards a pending write.
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) begin
                div_wr = 1'b1; div_ch = 1'b0; div_val = 8'd7;
            end
            step();
            div_wr = 1'b0;
        end
        check_eq("s6 sq pre-drop", 32'(sq), 32'd3);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("s6 async tick", 32'(tick), 32'd0);
        check_eq("s6 async sq", 32'(sq), 32'd0);
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            b0 = (e % 4 == 0);
            et = {b0, b0};
            check_eq($sformatf("s6 tick e%0d", e), 32'(tick), 32'(et));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
